// File: rtl/fifo_stream_pkg.sv
// Shared types, constants and helpers for the FIFO stream reader.
package fifo_stream_pkg;

  // Prefetch buffer depth covers the one-cycle FIFO read latency plus
  // enough slack to keep one beat per clock flowing.
  localparam int BUF_DEPTH  = 3;

  // A pop is allowed while buffered plus in-flight words do not exceed this.
  localparam int POP_THRESH = 2;

  typedef logic [1:0] count_t;
  typedef logic [1:0] ptr_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Circular pointer advance over BUF_DEPTH entries.
  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/stream_prefetch_buf.sv
// Three-entry circular buffer that absorbs the FIFO read latency.
// Head entry is presented combinationally from the storage registers.
module stream_prefetch_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output count_t                count_o
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  ptr_t                  r_head;
  ptr_t                  r_tail;
  count_t                r_count;

  // Storage, pointers and occupancy; writes land at the tail, reads retire the head.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      // NOTE: the storage is cleared too so the head word reads as zero out of reset.
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (wr_en_i) begin
        r_mem[r_tail] <= wr_data_i;
        r_tail        <= ptr_next(r_tail);
      end
      if (rd_en_i) r_head <= ptr_next(r_head);
      case ({wr_en_i, rd_en_i})
        2'b10:   r_count <= r_count + count_t'(1);
        2'b01:   r_count <= r_count - count_t'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data_o = r_mem[r_head];
  assign count_o   = r_count;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer of the dual-clock FIFO: pops words, prefetches them
// into a small buffer and presents a framed valid/ready stream.
// Optional build macro FIFO_STREAM_READER_STATS_EN adds beat/packet counters.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PKT_LEN    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [31:0]           beat_total_o,
  output logic [15:0]           pkt_total_o
`endif
);

  localparam int             BCW       = clog2_min1(PKT_LEN);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(PKT_LEN - 1);

  count_t         w_count;
  logic           w_pop;
  logic           w_fire;
  logic           r_inflight;
  logic [BCW-1:0] r_beat_cnt;

  // Pop only while the buffer can take every word already requested plus this one;
  // the decision never looks at m_ready_i, which keeps it off the downstream path.
  assign w_pop = !rst_i && !fifo_empty_i &&
                 (({1'b0, w_count} + {2'b00, r_inflight}) <= 3'(POP_THRESH));

  assign fifo_rd_en_o = w_pop;
  assign m_valid_o    = (w_count != '0);
  assign m_last_o     = m_valid_o && (r_beat_cnt == LAST_BEAT);
  assign w_fire       = m_valid_o && m_ready_i;

  stream_prefetch_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (r_inflight),
    .wr_data_i (fifo_rd_data_i),
    .rd_en_i   (w_fire),
    .rd_data_o (m_data_o),
    .count_o   (w_count)
  );

  // Track the word returning from the FIFO one cycle after each pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_inflight <= 1'b0;
    else       r_inflight <= w_pop;
  end

  // Beat position within the packet; wraps after the last beat fires.
  always_ff @(posedge clk_i) begin
    if (rst_i)       r_beat_cnt <= '0;
    else if (w_fire) r_beat_cnt <= m_last_o ? '0 : r_beat_cnt + BCW'(1);
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] r_beat_total;
  logic [15:0] r_pkt_total;

  // Saturating beat total and wrapping packet total.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_beat_total <= '0;
      r_pkt_total  <= '0;
    end else if (w_fire) begin
      if (r_beat_total != '1) r_beat_total <= r_beat_total + 32'd1;
      if (m_last_o)           r_pkt_total  <= r_pkt_total + 16'd1;
    end
  end

  assign beat_total_o = r_beat_total;
  assign pkt_total_o  = r_pkt_total;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a PKT_LEN=8 instance covers
// latency, throughput, stall, toggle and reset cases; a PKT_LEN=1
// instance covers every-beat-last framing and the optional counters.
module tb_fifo_stream_reader;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance 0: PKT_LEN = 8
  logic          rst0, ready0;
  logic          empty0   = 1'b1;
  logic [DW-1:0] rd_data0 = '0;
  logic          rd_en0, valid0, last0;
  logic [DW-1:0] data0;
  // Instance 1: PKT_LEN = 1
  logic          rst1, ready1;
  logic          empty1   = 1'b1;
  logic [DW-1:0] rd_data1 = '0;
  logic          rd_en1, valid1, last1;
  logic [DW-1:0] data1;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] beat_total0, beat_total1;
  logic [15:0] pkt_total0, pkt_total1;
`endif

  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(8)) dut0 (
    .clk_i          (clk),
    .rst_i          (rst0),
    .fifo_empty_i   (empty0),
    .fifo_rd_en_o   (rd_en0),
    .fifo_rd_data_i (rd_data0),
    .m_data_o       (data0),
    .m_valid_o      (valid0),
    .m_ready_i      (ready0),
    .m_last_o       (last0)
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    .beat_total_o   (beat_total0),
    .pkt_total_o    (pkt_total0)
`endif
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(1)) dut1 (
    .clk_i          (clk),
    .rst_i          (rst1),
    .fifo_empty_i   (empty1),
    .fifo_rd_en_o   (rd_en1),
    .fifo_rd_data_i (rd_data1),
    .m_data_o       (data1),
    .m_valid_o      (valid1),
    .m_ready_i      (ready1),
    .m_last_o       (last1)
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    .beat_total_o   (beat_total1),
    .pkt_total_o    (pkt_total1)
`endif
  );

  // FIFO read-side models: registered empty, data one cycle after rd_en,
  // read pointer flushed by the shared reset.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int pops0 = 0, under0 = 0, under1 = 0;

  always @(posedge clk) begin
    if (rst0) begin
      q0.delete();
      empty0 <= 1'b1;
    end else begin
      if (rd_en0 && q0.size() == 0) under0 <= under0 + 1;
      empty0 <= (q0.size() - ((rd_en0 && q0.size() != 0) ? 1 : 0)) == 0;
      if (rd_en0 && q0.size() != 0) begin
        rd_data0 <= q0.pop_front();
        pops0    <= pops0 + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst1) begin
      q1.delete();
      empty1 <= 1'b1;
    end else begin
      if (rd_en1 && q1.size() == 0) under1 <= under1 + 1;
      empty1 <= (q1.size() - ((rd_en1 && q1.size() != 0) ? 1 : 0)) == 0;
      if (rd_en1 && q1.size() != 0) rd_data1 <= q1.pop_front();
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] exp_data;
  int            exp_beat = 0;

  task automatic push0(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) q0.push_back(first + DW'(i));
  endtask

  // Run instance 0 for a number of cycles; ready held high or toggled 1,0,...
  task automatic run0(input int cycles, input bit toggle, output int beats);
    beats = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      ready0 = toggle ? (c % 2 == 0) : 1'b1;
      if (valid0 && ready0) begin
        check("beat_data", 32'(data0), 32'(exp_data));
        check("beat_last", 32'(last0), 32'(exp_beat % 8 == 7));
        exp_data = exp_data + 16'd1;
        exp_beat++;
        beats++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    int p;
    int n;

    rst0 = 1'b1; rst1 = 1'b1; ready0 = 1'b0; ready1 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_rd_en", 32'(rd_en0), 32'd0);
    check("rst_data",  32'(data0),  32'd0);
    check("rst_last",  32'(last0),  32'd0);
    rst0 = 1'b0; rst1 = 1'b0;

    // 1: idle with FIFO empty
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ready0 = 1'b1;
      check("t1_rd_en", 32'(rd_en0), 32'd0);
      check("t1_valid", 32'(valid0), 32'd0);
    end
    check("t1_beat_cnt", 32'(dut0.r_beat_cnt), 32'd0);

    // 2: 16 words streamed with ready high
    push0(16'h0001, 16); exp_data = 16'h0001;
    @(negedge clk); ready0 = 1'b1;
    check("t2_pop_N",    32'(rd_en0), 32'd1);
    check("t2_valid_N",  32'(valid0), 32'd0);
    @(negedge clk);
    check("t2_valid_N1", 32'(valid0), 32'd0);
    run0(16, 1'b0, beats);
    check("t2_beats", 32'(beats), 32'd16);
    @(negedge clk); ready0 = 1'b1;
    check("t2_drained", 32'(valid0), 32'd0);
    check("t2_underflow", 32'(under0), 32'd0);

    // 3: downstream stalled for 20 cycles
    ready0 = 1'b0; p = pops0;
    push0(16'h0001, 16); exp_data = 16'h0001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); ready0 = 1'b0;
      if (i >= 2) begin
        check("t3_hold_valid", 32'(valid0), 32'd1);
        check("t3_hold_data",  32'(data0),  32'h0001);
      end
    end
    check("t3_pops",  32'(pops0 - p), 32'd3);
    check("t3_count", 32'(dut0.w_count), 32'd3);
    run0(16, 1'b0, beats);
    check("t3_beats", 32'(beats), 32'd16);
    @(negedge clk); ready0 = 1'b1;
    check("t3_drained", 32'(valid0), 32'd0);

    // 4: ready toggling with a continuous supply
    ready0 = 1'b0;
    push0(16'h0001, 16); exp_data = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ready0 = 1'b0;
    end
    run0(16, 1'b1, beats);
    check("t4_beats_toggle", 32'(beats), 32'd8);
    run0(8, 1'b0, beats);
    check("t4_beats_rest", 32'(beats), 32'd8);
    @(negedge clk); ready0 = 1'b1;
    check("t4_drained", 32'(valid0), 32'd0);

    // 5: reset with two words buffered and one in flight, mid-packet
    push0(16'h0100, 3); exp_data = 16'h0100;
    run0(6, 1'b0, beats);
    check("t5_pre_beats", 32'(beats), 32'd3);
    ready0 = 1'b0;
    push0(16'h0200, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); ready0 = 1'b0;
    end
    check("t5_pre_count",    32'(dut0.w_count),    32'd2);
    check("t5_pre_inflight", 32'(dut0.r_inflight), 32'd1);
    rst0 = 1'b1;
    @(negedge clk);
    check("t5_rst_valid", 32'(valid0), 32'd0);
    check("t5_rst_rd_en", 32'(rd_en0), 32'd0);
    check("t5_rst_data",  32'(data0),  32'd0);
    check("t5_rst_beat",  32'(dut0.r_beat_cnt), 32'd0);
    rst0 = 1'b0; ready0 = 1'b1;
    push0(16'h00A1, 8); exp_data = 16'h00A1; exp_beat = 0;
    @(negedge clk); ready0 = 1'b1;
    check("t5_valid_N", 32'(valid0), 32'd0);
    @(negedge clk);
    check("t5_valid_N1", 32'(valid0), 32'd0);
    run0(8, 1'b0, beats);
    check("t5_beats", 32'(beats), 32'd8);
    check("t5_underflow", 32'(under0), 32'd0);
`ifdef FIFO_STREAM_READER_STATS_EN
    check("t5_beat_total", beat_total0, 32'd8);
    check("t5_pkt_total",  32'(pkt_total0), 32'd1);
`endif

    // 6: PKT_LEN=1, every beat is last
    for (int i = 0; i < 5; i++) q1.push_back(16'h0061 + 16'(i));
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); ready1 = 1'b1;
      if (valid1) begin
        check("t6_data", 32'(data1), 32'(16'h0061 + 16'(n)));
        check("t6_last", 32'(last1), 32'd1);
        n++;
      end
    end
    check("t6_beats", 32'(n), 32'd5);
    check("t6_underflow", 32'(under1), 32'd0);
`ifdef FIFO_STREAM_READER_STATS_EN
    check("t6_beat_total", beat_total1, 32'd5);
    check("t6_pkt_total",  32'(pkt_total1), 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
